// File: rtl/bfp_shift_calc.sv
// Block floating point shift calculator: ORs the sign-folded magnitudes of every
// I/Q sample in a block and reports the safe left shift and block length.
module bfp_shift_calc #(
  parameter int IW = 40,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic [IW-1:0] i_din_re,
  input  logic [IW-1:0] i_din_im,
  output logic [4:0]    o_shift_num,
  output logic          o_shift_vld,
  output logic [11:0]   o_blk_len,
  output logic          o_err
);

  localparam int AW        = IW - 1;
  localparam int MAX_SHIFT = IW - OW;
  localparam int LZW       = $clog2(IW) + 1;
  localparam logic [LZW-1:0] MAX_LZ  = LZW'(MAX_SHIFT);
  localparam logic [11:0]    CNT_MAX = 12'hFFF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  // Stage A: sign fold, so redundant sign bits become leading zeros.
  logic [AW-1:0] a_re, a_im;
  logic          a_vld, a_sop, a_eop;

  // NOTE: data registers are reset too, so no X ever reaches the OR accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_re  <= '0;
      a_im  <= '0;
      a_vld <= 1'b0;
      a_sop <= 1'b0;
      a_eop <= 1'b0;
    end else begin
      a_re  <= i_din_re[IW-2:0] ^ {AW{i_din_re[IW-1]}};
      a_im  <= i_din_im[IW-2:0] ^ {AW{i_din_im[IW-1]}};
      a_vld <= i_vld;
      a_sop <= i_vld & i_sop;
      a_eop <= i_vld & i_eop;
    end
  end

  // Stage B: block state machine, accumulator and snapshot.
  logic [0:0]    state;
  logic [AW-1:0] acc, snap;
  logic [11:0]   cnt, snap_cnt;
  logic          snap_vld;
  logic [AW-1:0] a_mag;
  logic [11:0]   cnt_inc;

  assign a_mag   = a_re | a_im;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 12'd1;

  // NOTE: every state register uses <=, so all reads in this block see the
  // previous-cycle value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      snap     <= '0;
      snap_cnt <= '0;
      snap_vld <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      o_err    <= 1'b0;
      if (a_vld) begin
        if (a_sop) begin
          // A sop inside an open block drops that block and restarts here.
          o_err <= (state == ACC);
          acc   <= a_mag;
          cnt   <= 12'd1;
          if (a_eop) begin
            snap     <= a_mag;
            snap_cnt <= 12'd1;
            snap_vld <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= ACC;
          end
        end else if (state == ACC) begin
          acc <= acc | a_mag;
          cnt <= cnt_inc;
          if (a_eop) begin
            snap     <= acc | a_mag;
            snap_cnt <= cnt_inc;
            snap_vld <= 1'b1;
            state    <= IDLE;
          end
        end else if (a_eop) begin
          o_err <= 1'b1;
        end
      end
    end
  end

  // Stage C: leading-zero count of the snapshot, clamped to the shift range.
  function automatic logic [LZW-1:0] lead_zeros(input logic [AW-1:0] v);
    lead_zeros = LZW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (v[i]) lead_zeros = LZW'(AW - 1 - i);
    end
  endfunction

  logic [LZW-1:0] lz;
  logic [4:0]     shift_c;

  assign lz      = lead_zeros(snap);
  assign shift_c = (lz > MAX_LZ) ? 5'(MAX_SHIFT) : 5'(lz);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_shift_num <= '0;
      o_blk_len   <= '0;
      o_shift_vld <= 1'b0;
    end else begin
      o_shift_vld <= snap_vld;
      if (snap_vld) begin
        o_shift_num <= shift_c;
        o_blk_len   <= snap_cnt;
      end
    end
  end

endmodule

// File: tb/tb_bfp_shift_calc.sv
// Directed bench for bfp_shift_calc: result values, pulse timing, error
// pulses, reset behaviour and count saturation.
module tb_bfp_shift_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld, i_sop, i_eop;
  logic [39:0] i_din_re, i_din_im;
  logic [4:0]  o_shift_num;
  logic        o_shift_vld;
  logic [11:0] o_blk_len;
  logic        o_err;

  bfp_shift_calc #(.IW(40), .OW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_vld       (i_vld),
    .i_sop       (i_sop),
    .i_eop       (i_eop),
    .i_din_re    (i_din_re),
    .i_din_im    (i_din_im),
    .o_shift_num (o_shift_num),
    .o_shift_vld (o_shift_vld),
    .o_blk_len   (o_blk_len),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [4:0]  num;
    logic [11:0] len;
  } pulse_t;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  pulse_t pq[$];
  int     eq[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (o_shift_vld === 1'b1) pq.push_back('{cyc, o_shift_num, o_blk_len});
    if (o_err === 1'b1) eq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [39:0] re, input logic [39:0] im, output int c);
    @(negedge clk);
    #1;
    i_vld = v; i_sop = s; i_eop = e; i_din_re = re; i_din_im = im;
    c = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, c);
  endtask

  task automatic check_pulse(input string tag, input int exp_c,
                             input logic [4:0] num, input logic [11:0] len);
    pulse_t p;
    check({tag, "_present"}, 64'(pq.size() > 0), 64'd1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      check({tag, "_cycle"}, 64'(p.c), 64'(exp_c));
      check({tag, "_shift"}, 64'(p.num), 64'(num));
      check({tag, "_len"}, 64'(p.len), 64'(len));
    end
  endtask

  task automatic single(input string tag, input logic [39:0] re, input logic [39:0] im,
                        input logic [4:0] num);
    int c;
    drive(1'b1, 1'b1, 1'b1, re, im, c);
    idle(6);
    check_pulse(tag, c + 3, num, 12'd1);
  endtask

  localparam logic [39:0] ALL_ONES = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] MAX_POS  = 40'h7F_FFFF_FFFF;

  initial begin
    int c, c_eop, c_sop2;

    rst = 1'b1; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    i_din_re = '0; i_din_im = '0;
    idle(3);
    check("rst_shift_num", 64'(o_shift_num), 64'd0);
    check("rst_shift_vld", 64'(o_shift_vld), 64'd0);
    check("rst_blk_len", 64'(o_blk_len), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    @(negedge clk); #1; rst = 1'b0;
    idle(2);

    // 4-sample block with an ignored gap carrying junk tags and data.
    drive(1'b1, 1'b1, 1'b0, '0, '0, c);
    drive(1'b1, 1'b0, 1'b0, 40'h00_0080_0000, '0, c);
    drive(1'b0, 1'b1, 1'b1, MAX_POS, MAX_POS, c);
    drive(1'b1, 1'b0, 1'b0, '0, '0, c);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c_eop);
    drive(1'b0, 1'b0, 1'b0, '0, '0, c);
    check("b4_no_early_pulse", 64'(o_shift_vld), 64'd0);
    idle(6);
    check_pulse("b4", c_eop + 3, 5'd15, 12'd4);
    check("b4_held", 64'(o_shift_num), 64'd15);

    single("s_neg", 40'hFF_FF80_0000, '0, 5'd16);
    single("s_min", 40'h80_0000_0000, '0, 5'd0);
    single("s_zero", '0, '0, 5'd24);
    single("s_m1", ALL_ONES, ALL_ONES, 5'd24);
    single("s_im", '0, 40'h00_0001_0000, 5'd22);

    // Back-to-back blocks: eop at T, sop at T+1, second eop at T+8.
    drive(1'b1, 1'b1, 1'b0, 40'h00_0000_1000, '0, c);
    drive(1'b1, 1'b0, 1'b0, '0, 40'h00_0000_0003, c);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c_eop);
    drive(1'b1, 1'b1, 1'b0, '0, 40'hFF_FFFF_FFFB, c);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 40'h00_0000_0010, '0, c);
    drive(1'b1, 1'b0, 1'b0, 40'h00_4000_0000, '0, c);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, c);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c);
    idle(6);
    check("b2b_eop_spacing", 64'(c - c_eop), 64'd8);
    check_pulse("b2b_a", c_eop + 3, 5'd24, 12'd3);
    check_pulse("b2b_b", c + 3, 5'd8, 12'd8);
    check("b2b_no_err", 64'(eq.size()), 64'd0);

    // sop inside an open block: error, first block dropped, second kept.
    drive(1'b1, 1'b1, 1'b0, MAX_POS, '0, c);
    drive(1'b1, 1'b0, 1'b0, '0, '0, c);
    drive(1'b1, 1'b1, 1'b0, 40'h00_0010_0000, '0, c_sop2);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c_eop);
    idle(6);
    check("resop_err_count", 64'(eq.size()), 64'd1);
    if (eq.size() > 0) check("resop_err_cycle", 64'(eq.pop_front()), 64'(c_sop2 + 2));
    check_pulse("resop", c_eop + 3, 5'd18, 12'd2);
    check("resop_only_one", 64'(pq.size()), 64'd0);

    // Plain sample and orphan eop in IDLE: no result, eop raises error.
    drive(1'b1, 1'b0, 1'b0, MAX_POS, '0, c);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c_eop);
    idle(6);
    check("orphan_err_count", 64'(eq.size()), 64'd1);
    if (eq.size() > 0) check("orphan_err_cycle", 64'(eq.pop_front()), 64'(c_eop + 2));
    check("orphan_no_pulse", 64'(pq.size()), 64'd0);

    // One-cycle reset two samples before eop discards the block.
    drive(1'b1, 1'b1, 1'b0, 40'h00_0000_0100, '0, c);
    drive(1'b1, 1'b0, 1'b0, '0, '0, c);
    @(negedge clk); #1;
    rst = 1'b1; i_vld = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_din_re = '0; i_din_im = '0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, c);
    rst = 1'b0;
    check("mrst_shift_num", 64'(o_shift_num), 64'd0);
    check("mrst_shift_vld", 64'(o_shift_vld), 64'd0);
    check("mrst_blk_len", 64'(o_blk_len), 64'd0);
    check("mrst_err", 64'(o_err), 64'd0);
    drive(1'b1, 1'b0, 1'b1, '0, '0, c);
    idle(6);
    check("mrst_no_pulse", 64'(pq.size()), 64'd0);
    eq.delete();
    drive(1'b1, 1'b1, 1'b0, 40'hFF_FF80_0000, '0, c);
    drive(1'b1, 1'b0, 1'b1, '0, 40'h00_0001_0000, c_eop);
    idle(6);
    check_pulse("mrst_clean", c_eop + 3, 5'd16, 12'd2);

    // 4100-sample block: length saturates at 4095.
    drive(1'b1, 1'b1, 1'b0, '0, '0, c);
    for (int i = 0; i < 4098; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, (i == 2000) ? 40'hF8_0000_0000 : 40'h0, c);
    end
    drive(1'b1, 1'b0, 1'b1, '0, '0, c_eop);
    idle(6);
    check_pulse("sat", c_eop + 3, 5'd4, 12'd4095);
    check("final_no_pulse", 64'(pq.size()), 64'd0);
    check("final_no_err", 64'(eq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
